// File: rtl/plotter_pkg.sv
// Shared definitions for the plotter motion blocks: axis FSM state codes,
// direction codes, datapath widths and the step-interval clamp.
package plotter_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LOW   = 2'd3;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    localparam int CNT_W = 24;
    localparam int POS_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SETUP = S_SETUP,
        ST_HIGH  = S_HIGH,
        ST_LOW   = S_LOW
    } axis_state_e;

    // Interval in ticks: raised to the minimum, capped to the counter range.
    function automatic logic [CNT_W-1:0] clamp_iv(
        input logic [31:0] spd,
        input logic [31:0] min_iv
    );
        logic [31:0] v;
        v = (spd < min_iv) ? min_iv : spd;
        if (v > 32'h00FF_FFFF) begin
            v = 32'h00FF_FFFF;
        end
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/stepper_axis.sv
// One step/dir axis: IDLE/SETUP/HIGH/LOW FSM, tick counter, signed position.
// Ports: clk_i, rst_ni (async low), tick_i, enable_i, speed_i, dir_i in;
//        step_o, dir_o, pos_o, busy_o out (all registered).
module stepper_axis
    import plotter_pkg::*;
#(
    parameter int PULSE_TICKS     = 5,
    parameter int DIR_SETUP_TICKS = 10,
    parameter int MIN_INTERVAL    = 20
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             enable_i,
    input  logic [31:0]      speed_i,
    input  logic             dir_i,
    output logic             step_o,
    output logic             dir_o,
    output logic [POS_W-1:0] pos_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] PULSE_CNT = CNT_W'(PULSE_TICKS);
    localparam logic [CNT_W-1:0] SETUP_CNT = CNT_W'(DIR_SETUP_TICKS);
    localparam logic [31:0]      MIN_IV    = 32'(MIN_INTERVAL);

    axis_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] iv_q, iv_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;

    logic go;
    logic eval;
    logic start;
    logic last;

    assign go   = enable_i && (speed_i != '0);
    assign last = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iv_d    = iv_q;
        step_d  = step_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        eval    = 1'b0;
        start   = 1'b0;

        if (tick_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    eval = 1'b1;
                end
                ST_SETUP: begin
                    // Speed is deliberately not re-checked: a stop
                    // during setup still yields this one step.
                    if (last) begin
                        start = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (last) begin
                        step_d  = 1'b0;
                        cnt_d   = iv_q - PULSE_CNT;
                        state_d = ST_LOW;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_LOW: begin
                    if (last) begin
                        eval = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            endcase
        end

        // Step boundary: decide between stop, direction setup, next step.
        if (eval) begin
            if (!go) begin
                state_d = ST_IDLE;
            end else if (dir_i != dir_q) begin
                dir_d   = dir_i;
                cnt_d   = SETUP_CNT;
                state_d = ST_SETUP;
            end else begin
                start = 1'b1;
            end
        end

        if (start) begin
            step_d  = 1'b1;
            iv_d    = clamp_iv(speed_i, MIN_IV);
            cnt_d   = PULSE_CNT;
            state_d = ST_HIGH;
            pos_d   = (dir_q == DIR_NEG) ? pos_q - 1'b1 : pos_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            iv_q    <= '0;
            step_q  <= 1'b0;
            dir_q   <= DIR_POS;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iv_q    <= iv_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
        end
    end

    assign step_o = step_q;
    assign dir_o  = dir_q;
    assign pos_o  = pos_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/stepper_pulse_gen.sv
// Two-axis STEP/DIR pulse generator: shared tick prescaler + two axes.
// Ports: clock, reset (async low), enable, x/y_speed, x/y_direction in;
//        pin_X/YSpeed, pin_X/YDir, x/y_pos, x/y_busy out.
module stepper_pulse_gen
    import plotter_pkg::*;
#(
    parameter int TICK_DIV        = 100,
    parameter int PULSE_TICKS     = 5,
    parameter int DIR_SETUP_TICKS = 10,
    parameter int MIN_INTERVAL    = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] x_speed,
    input  logic [31:0] x_direction,
    input  logic [31:0] y_speed,
    input  logic [31:0] y_direction,
    output logic        pin_XSpeed,
    output logic        pin_XDir,
    output logic        pin_YSpeed,
    output logic        pin_YDir,
    output logic [31:0] x_pos,
    output logic [31:0] y_pos,
    output logic        x_busy,
    output logic        y_busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    // Only bit 0 of each direction word carries meaning.
    logic unused_dir_bits;
    assign unused_dir_bits = ^{x_direction[31:1], y_direction[31:1]};

    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    stepper_axis #(
        .PULSE_TICKS    (PULSE_TICKS),
        .DIR_SETUP_TICKS(DIR_SETUP_TICKS),
        .MIN_INTERVAL   (MIN_INTERVAL)
    ) u_x (
        .clk_i   (clock),
        .rst_ni  (reset),
        .tick_i  (tick),
        .enable_i(enable),
        .speed_i (x_speed),
        .dir_i   (x_direction[0]),
        .step_o  (pin_XSpeed),
        .dir_o   (pin_XDir),
        .pos_o   (x_pos),
        .busy_o  (x_busy)
    );

    stepper_axis #(
        .PULSE_TICKS    (PULSE_TICKS),
        .DIR_SETUP_TICKS(DIR_SETUP_TICKS),
        .MIN_INTERVAL   (MIN_INTERVAL)
    ) u_y (
        .clk_i   (clock),
        .rst_ni  (reset),
        .tick_i  (tick),
        .enable_i(enable),
        .speed_i (y_speed),
        .dir_i   (y_direction[0]),
        .step_o  (pin_YSpeed),
        .dir_o   (pin_YDir),
        .pos_o   (y_pos),
        .busy_o  (y_busy)
    );

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Bench for stepper_pulse_gen: tick-time event model in lockstep plus
// per-scenario timing checks on the STEP/DIR pins.
module tb_stepper_pulse_gen;

    localparam int TD = 4;
    localparam int PT = 5;
    localparam int DS = 10;
    localparam int MI = 20;
    localparam int M_IDLE  = 0;
    localparam int M_SETUP = 1;
    localparam int M_RUN   = 2;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [31:0] x_speed, x_direction, y_speed, y_direction;
    logic        pin_XSpeed, pin_XDir, pin_YSpeed, pin_YDir;
    logic [31:0] x_pos, y_pos;
    logic        x_busy, y_busy;

    stepper_pulse_gen #(.TICK_DIV(TD)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .x_speed    (x_speed),
        .x_direction(x_direction),
        .y_speed    (y_speed),
        .y_direction(y_direction),
        .pin_XSpeed (pin_XSpeed),
        .pin_XDir   (pin_XDir),
        .pin_YSpeed (pin_YSpeed),
        .pin_YDir   (pin_YDir),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .x_busy     (x_busy),
        .y_busy     (y_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Axis model in absolute tick numbers: a step rising at tick r falls
    // at r+PT and its next decision point is r+IV; a direction change
    // decided at tick t rises at t+DS.
    typedef struct {
        int          mode;
        bit          dir;
        bit          step;
        logic [31:0] pos;
        int          rise_t;
        int          setup_end;
        int          iv;
    } ax_t;

    function automatic ax_t ax_tick(ax_t m, int t, bit en,
                                    logic [31:0] spd, bit d);
        ax_t r;
        bit  ev;
        bit  rise;
        r    = m;
        ev   = 1'b0;
        rise = 1'b0;
        if (r.mode == M_IDLE) begin
            ev = 1'b1;
        end else if (r.mode == M_SETUP) begin
            rise = (t == r.setup_end);
        end else begin
            if (t == r.rise_t + PT) r.step = 1'b0;
            if (t == r.rise_t + r.iv) ev = 1'b1;
        end
        if (ev) begin
            if (!en || spd == 32'd0) begin
                r.mode = M_IDLE;
            end else if (d != r.dir) begin
                r.dir       = d;
                r.mode      = M_SETUP;
                r.setup_end = t + DS;
            end else begin
                rise = 1'b1;
            end
        end
        if (rise) begin
            r.step   = 1'b1;
            r.mode   = M_RUN;
            r.rise_t = t;
            if (spd < 32'(MI)) r.iv = MI;
            else if (spd > 32'h00FF_FFFF) r.iv = 32'h00FF_FFFF;
            else r.iv = int'(spd);
            r.pos = r.dir ? r.pos - 32'd1 : r.pos + 32'd1;
        end
        return r;
    endfunction

    ax_t         mx, my;
    int          cc, tk;
    logic        ldx;
    logic [31:0] ldv;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cc <= 0;
            tk <= 0;
            mx <= '{M_IDLE, 1'b0, 1'b0, 32'd0, 0, 0, 0};
            my <= '{M_IDLE, 1'b0, 1'b0, 32'd0, 0, 0, 0};
        end else begin
            cc <= (cc == TD - 1) ? 0 : cc + 1;
            if (cc == TD - 1) begin
                tk <= tk + 1;
                mx <= ax_tick(mx, tk, enable, x_speed, x_direction[0]);
                my <= ax_tick(my, tk, enable, y_speed, y_direction[0]);
            end
            if (ldx) mx.pos <= ldv;
        end
    end

    logic [69:0] dut_v, exp_v;
    assign dut_v = {pin_XSpeed, pin_XDir, pin_YSpeed, pin_YDir,
                    x_busy, y_busy, x_pos, y_pos};
    assign exp_v = {mx.step, mx.dir, my.step, my.dir,
                    mx.mode != M_IDLE, my.mode != M_IDLE, mx.pos, my.pos};

    always @(negedge clock) begin
        n_checks++;
        if (dut_v !== exp_v) begin
            n_fail++;
            $display("FAIL lockstep t=%0t dut=%h model=%h",
                     $time, dut_v, exp_v);
        end
    end

    // Edge/timing capture, in clock cycles from the start of a window.
    int xr[$], xh[$], yr[$], yh[$];
    int xt, viol;

    task automatic watch(input int n);
        logic px, py, pd;
        int   rx, ry;
        xr.delete(); xh.delete(); yr.delete(); yh.delete();
        xt = -1; viol = 0; rx = -1; ry = -1;
        px = pin_XSpeed; py = pin_YSpeed; pd = pin_XDir;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (pin_XSpeed && !px) begin xr.push_back(i); rx = i; end
            if (!pin_XSpeed && px && rx >= 0) xh.push_back(i - rx);
            if (pin_YSpeed && !py) begin yr.push_back(i); ry = i; end
            if (!pin_YSpeed && py && ry >= 0) yh.push_back(i - ry);
            if (pin_XDir != pd) begin
                if (xt < 0) xt = i;
                if (pin_XSpeed || px) viol++;
            end
            px = pin_XSpeed; py = pin_YSpeed; pd = pin_XDir;
        end
    endtask

    task automatic wait_x(input bit lvl, input int lim, output int c);
        logic p;
        p = pin_XSpeed;
        for (c = 1; c <= lim; c++) begin
            @(negedge clock);
            if (pin_XSpeed == lvl && p != lvl) return;
            p = pin_XSpeed;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_x_%0b timeout after %0d clocks", lvl, lim);
    endtask

    task automatic wait_idle(input int lim);
        int c;
        for (c = 0; c < lim && x_busy; c++) @(negedge clock);
        n_checks++;
        if (x_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle x_busy=%b want 0", x_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1;
        x_speed = 32'd50; x_direction = 0;
        y_speed = 0; y_direction = 0;
        repeat (5) @(negedge clock);
        n_checks++;
        if (dut_v !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want 0", dut_v);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        watch(900);
        n_checks++;
        if (xr.size() < 4 || xr[0] > 2 * TD) begin
            n_fail++;
            $display("FAIL basic_first rises=%0d first=%0d want>=4,<=%0d",
                     xr.size(), xr.size() ? xr[0] : -1, 2 * TD);
        end
        for (int k = 1; k < xr.size(); k++) begin
            n_checks++;
            if (xr[k] - xr[k-1] != 200) begin
                n_fail++;
                $display("FAIL basic_period got=%0d want 200",
                         xr[k] - xr[k-1]);
            end
        end
        foreach (xh[k]) begin
            n_checks++;
            if (xh[k] != 20) begin
                n_fail++;
                $display("FAIL basic_high got=%0d want 20", xh[k]);
            end
        end
        n_checks++;
        if (x_pos !== 32'(xr.size())) begin
            n_fail++;
            $display("FAIL basic_pos got=%0d want %0d", x_pos, xr.size());
        end
    endtask

    task automatic test_clamp_stop();
        int c;
        x_speed = 32'd3;
        watch(400);
        n_checks++;
        if (xr.size() < 3) begin
            n_fail++;
            $display("FAIL clamp_rises got=%0d want>=3", xr.size());
        end
        for (int k = 2; k < xr.size(); k++) begin
            n_checks++;
            if (xr[k] - xr[k-1] != 80) begin
                n_fail++;
                $display("FAIL clamp_period got=%0d want 80",
                         xr[k] - xr[k-1]);
            end
        end
        wait_x(1'b1, 200, c);
        repeat (3) @(negedge clock);
        x_speed = 32'd0;
        wait_x(1'b0, 100, c);
        n_checks++;
        if (c + 3 != 20) begin
            n_fail++;
            $display("FAIL stop_high got=%0d want 20", c + 3);
        end
        watch(200);
        n_checks++;
        if (xr.size() != 0 || x_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle rises=%0d busy=%b want 0 0",
                     xr.size(), x_busy);
        end
    endtask

    task automatic test_dir_change();
        int          c;
        logic [31:0] p0;
        x_speed = 32'd25;
        x_direction = 0;
        wait_x(1'b1, 100, c);
        repeat ($urandom_range(60)) @(negedge clock);
        x_direction = 32'd1;
        p0 = x_pos;
        watch(500);
        n_checks++;
        if (xt < 0 || viol != 0) begin
            n_fail++;
            $display("FAIL dir_toggle at=%0d viol=%0d want >=0 0", xt, viol);
        end
        n_checks++;
        if (xr.size() == 0 || xr[0] - xt < 4 * DS) begin
            n_fail++;
            $display("FAIL dir_setup gap=%0d want>=%0d",
                     xr.size() ? xr[0] - xt : -1, 4 * DS);
        end
        n_checks++;
        if (p0 - x_pos !== 32'(xr.size())) begin
            n_fail++;
            $display("FAIL dir_pos dec=%0d want %0d", p0 - x_pos, xr.size());
        end
    endtask

    task automatic preload(input logic [31:0] v);
        @(negedge clock);
        #2;
        force dut.u_x.pos_q = v;
        ldv = v; ldx = 1'b1;
        @(posedge clock);
        #1 ldx = 1'b0;
        @(negedge clock);
        #2 release dut.u_x.pos_q;
    endtask

    task automatic test_wrap();
        int c;
        x_speed = 32'd0;
        wait_idle(200);
        preload(32'h7FFF_FFFF);
        x_direction = 0;
        x_speed = 32'd40;
        wait_x(1'b1, 200, c);
        n_checks++;
        if (x_pos !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL wrap_pos got=%h want 80000000", x_pos);
        end
        x_speed = 32'd0;
        wait_idle(300);
        preload(32'd0);
        x_direction = 32'd1;
        x_speed = 32'd40;
        wait_x(1'b1, 200, c);
        n_checks++;
        if (x_pos !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_neg got=%h want ffffffff", x_pos);
        end
    endtask

    task automatic test_enable_reset();
        int c;
        x_speed = 32'd30;
        wait_x(1'b0, 200, c);
        repeat (5) @(negedge clock);
        enable = 1'b0;
        watch(200);
        n_checks++;
        if (xr.size() != 0 || x_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_idle rises=%0d busy=%b want 0 0",
                     xr.size(), x_busy);
        end
        enable = 1'b1;
        wait_x(1'b1, 200, c);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (pin_XSpeed !== 1'b0 || x_pos !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset step=%b pos=%h want 0 0",
                     pin_XSpeed, x_pos);
        end
        x_speed = 32'd0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_two_axis();
        x_direction = 0; y_direction = 0;
        x_speed = 32'd20; y_speed = 32'd33;
        watch(700);
        n_checks++;
        if (xr.size() < 3 || yr.size() < 3) begin
            n_fail++;
            $display("FAIL xy_rises x=%0d y=%0d want>=3",
                     xr.size(), yr.size());
        end
        for (int k = 1; k < xr.size(); k++) begin
            n_checks++;
            if (xr[k] - xr[k-1] != 80) begin
                n_fail++;
                $display("FAIL x_period got=%0d want 80", xr[k] - xr[k-1]);
            end
        end
        for (int k = 1; k < yr.size(); k++) begin
            n_checks++;
            if (yr[k] - yr[k-1] != 132) begin
                n_fail++;
                $display("FAIL y_period got=%0d want 132", yr[k] - yr[k-1]);
            end
        end
        n_checks++;
        if (x_pos !== 32'(xr.size()) || y_pos !== 32'(yr.size())) begin
            n_fail++;
            $display("FAIL xy_pos x=%0d y=%0d want %0d %0d",
                     x_pos, y_pos, xr.size(), yr.size());
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 8; s++) begin
            x_speed = ($urandom_range(3) == 0) ? 0 : $urandom_range(60);
            y_speed = ($urandom_range(3) == 0) ? 0 : $urandom_range(60);
            x_direction = 32'($urandom_range(1));
            y_direction = 32'($urandom_range(1));
            enable = ($urandom_range(4) != 0);
            repeat ($urandom_range(400, 150)) @(negedge clock);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0;
        x_speed = 0; x_direction = 0; y_speed = 0; y_direction = 0;
        ldx = 1'b0; ldv = 0;
        test_reset();
        test_basic();
        test_clamp_stop();
        test_dir_change();
        test_wrap();
        test_enable_reset();
        test_two_axis();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
